hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-002 SHALL have port clk, input, 1: pipeline clock; all state updates on the falling edge.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports id_rs1 and id_rs2, input, 5 each: source register fields of the instruction in ID.
REQ-005 SHALL have ports id_uses_rs1 and id_uses_rs2, input, 1 each: the ID instruction reads that source.
REQ-006 SHALL have ports ex_mem_read, input, 1, and ex_rd, input, 5: load flag and destination of the instruction in EX.
REQ-007 SHALL have port ex_redirect, input, 1: taken branch, jal or jalr resolved in EX.
REQ-008 SHALL have ports mem_req and mem_ready, input, 1 each: data-memory request/ready handshake from MEM.
REQ-009 SHALL have port stat_clr, input, 1: synchronous clear of both counters.
REQ-010 SHALL have ports hold_pc, hold_if_id and hold_id_ex, output, 1 each: freeze the PC and the corresponding pipeline register.
REQ-011 SHALL have ports flush_if_id and bubble_id_ex, output, 1 each: zero IF/ID, or load zero control bits into ID/EX.
REQ-012 SHALL have port freeze_all, output, 1: stall EX/MEM and MEM/WB.
REQ-013 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each: counter values.
REQ-014 SHALL have port state_o, output, 2: current FSM state (RUN=0, LU_STALL=1, MEM_WAIT=2).

Function
REQ-015 SHALL define hazard lu = ex_mem_read AND ex_rd!=0 AND ((id_uses_rs1 AND id_rs1==ex_rd) OR (id_uses_rs2 AND id_rs2==ex_rd)).
REQ-016 SHALL define mw = mem_req AND NOT mem_ready.
REQ-017 SHALL drive all control outputs combinationally from the current state and the inputs, with priority mw > ex_redirect > lu.
REQ-018 In RUN with mw: freeze_all=hold_pc=hold_if_id=hold_id_ex=1, other controls 0; next state MEM_WAIT.
REQ-019 In RUN with ex_redirect and no mw: flush_if_id=1 and bubble_id_ex=1, holds 0; next state RUN; a simultaneous lu is discarded.
REQ-020 In RUN with lu only: hold_pc=hold_if_id=1 and bubble_id_ex=1; next state LU_STALL.
REQ-021 In RUN with no event: all controls 0; remain in RUN.
REQ-022 In LU_STALL, lu SHALL be ignored because EX holds a bubble. mw and ex_redirect SHALL be handled as in RUN, and the next state SHALL be MEM_WAIT or RUN accordingly.
REQ-023 In MEM_WAIT, the REQ-018 outputs SHALL be held while mw=1. The first cycle with mw=0 SHALL drive all controls 0 and return to RUN. ex_redirect and lu SHALL be ignored while mw=1.
REQ-024 stall_cnt SHALL increment on every falling edge where hold_pc=1.
REQ-025 flush_cnt SHALL increment on every falling edge where flush_if_id=1.
REQ-026 Both counters SHALL saturate at 2^CNT_W-1 with no wrap-around.
REQ-027 stat_clr SHALL zero both counters on that edge and take priority over an increment in the same cycle.
REQ-028 Unreachable state encoding 3 SHALL behave as RUN and transition as RUN.

Reset
REQ-029 While reset=0: state=RUN, stall_cnt=flush_cnt=0, and all control outputs forced to 0 regardless of inputs.
REQ-030 Reset asserted in MEM_WAIT or LU_STALL SHALL abort that state immediately; after release the block starts in RUN.

Verification
REQ-031 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> hold_pc=hold_if_id=bubble_id_ex=1 for exactly one cycle; LU_STALL, then RUN; stall_cnt=1.
REQ-032 x0 and unused source: ex_rd=0, or id_uses_rs2=0 with rs2 matching -> no stall; stall_cnt unchanged.
REQ-033 Redirect plus load-use in the same cycle -> flush_if_id=bubble_id_ex=1, hold_pc=0, state stays RUN; flush_cnt=1, stall_cnt=0.
REQ-034 mem_req=1 with mem_ready=0 for 3 cycles, ex_redirect=1 throughout -> freeze_all=1 for 3 cycles and no flush. mem_ready=1 -> RUN; stall_cnt=3.
REQ-035 CNT_W=4 with 20 load-use events -> stall_cnt saturates at 15. stat_clr together with an event -> 0.
REQ-036 reset pulsed low mid-MEM_WAIT -> outputs 0 immediately; state_o=0 and counters 0 after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller covering load-use stalls, EX
//               redirect flushes and data-memory wait freezes, with
//               saturating statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             stat_clr,
    output logic             hold_pc,
    output logic             hold_if_id,
    output logic             hold_id_ex,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             freeze_all,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        UNUSED   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu_hazard;
    logic mem_wait;
    logic hold_pc_c, hold_if_id_c, hold_id_ex_c;
    logic flush_if_id_c, bubble_id_ex_c, freeze_all_c;

    assign lu_hazard = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign mem_wait  = mem_req && !mem_ready;

    always_comb begin
        state_d        = state_q;
        hold_pc_c      = 1'b0;
        hold_if_id_c   = 1'b0;
        hold_id_ex_c   = 1'b0;
        flush_if_id_c  = 1'b0;
        bubble_id_ex_c = 1'b0;
        freeze_all_c   = 1'b0;
        case (state_q)
            MEM_WAIT: begin
                if (mem_wait) begin
                    freeze_all_c = 1'b1;
                    hold_pc_c    = 1'b1;
                    hold_if_id_c = 1'b1;
                    hold_id_ex_c = 1'b1;
                    state_d      = MEM_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            // EX holds the bubble we inserted, so a load-use match here is stale.
            LU_STALL: begin
                if (mem_wait) begin
                    freeze_all_c = 1'b1;
                    hold_pc_c    = 1'b1;
                    hold_if_id_c = 1'b1;
                    hold_id_ex_c = 1'b1;
                    state_d      = MEM_WAIT;
                end else if (ex_redirect) begin
                    flush_if_id_c  = 1'b1;
                    bubble_id_ex_c = 1'b1;
                    state_d        = RUN;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                if (mem_wait) begin
                    freeze_all_c = 1'b1;
                    hold_pc_c    = 1'b1;
                    hold_if_id_c = 1'b1;
                    hold_id_ex_c = 1'b1;
                    state_d      = MEM_WAIT;
                end else if (ex_redirect) begin
                    flush_if_id_c  = 1'b1;
                    bubble_id_ex_c = 1'b1;
                    state_d        = RUN;
                end else if (lu_hazard) begin
                    hold_pc_c      = 1'b1;
                    hold_if_id_c   = 1'b1;
                    bubble_id_ex_c = 1'b1;
                    state_d        = LU_STALL;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    // Controls are forced low for as long as reset is held, independent of state.
    assign hold_pc      = reset & hold_pc_c;
    assign hold_if_id   = reset & hold_if_id_c;
    assign hold_id_ex   = reset & hold_id_ex_c;
    assign flush_if_id  = reset & flush_if_id_c;
    assign bubble_id_ex = reset & bubble_id_ex_c;
    assign freeze_all   = reset & freeze_all_c;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stat_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (hold_pc && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_d = stall_cnt_q + 1'b1;
            if (flush_if_id && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state_o   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
    logic       mem_req, mem_ready, stat_clr;

    logic       hold_pc, hold_if_id, hold_id_ex, flush_if_id, bubble_id_ex, freeze_all;
    logic [3:0] stall_cnt, flush_cnt;
    logic [1:0] state_o;

    logic        h16_pc, h16_ifid, h16_idex, f16_ifid, b16_idex, fz16;
    logic [15:0] stall16, flush16;
    logic [1:0]  state16;

    int n_cmp = 0;
    int n_err = 0;

    // Control vector order: {freeze_all, hold_pc, hold_if_id, hold_id_ex, flush_if_id, bubble_id_ex}
    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_LU     = 6'b011001;
    localparam logic [5:0] C_FLUSH  = 6'b000011;
    localparam logic [5:0] C_FREEZE = 6'b111100;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready), .stat_clr(stat_clr),
        .hold_pc(hold_pc), .hold_if_id(hold_if_id), .hold_id_ex(hold_id_ex),
        .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex), .freeze_all(freeze_all),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_o(state_o)
    );

    hazard_ctrl dut16 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready), .stat_clr(stat_clr),
        .hold_pc(h16_pc), .hold_if_id(h16_ifid), .hold_id_ex(h16_idex),
        .flush_if_id(f16_ifid), .bubble_id_ex(b16_idex), .freeze_all(fz16),
        .stall_cnt(stall16), .flush_cnt(flush16), .state_o(state16)
    );

    function automatic logic [5:0] ctl();
        return {freeze_all, hold_pc, hold_if_id, hold_id_ex, flush_if_id, bubble_id_ex};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1; stat_clr = 1'b0;
    endtask

    // State updates on the falling edge; inputs change and checks happen after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1; set_lu();
        #2;
        chk("rst_ctl", ctl(), C_NONE);
        chk("rst_state", state_o, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_flush", flush_cnt, 0);
        tick();
        idle();
        reset = 1'b1;
        tick();

        // Load-use stall for exactly one cycle
        set_lu(); #1;
        chk("lu_ctl", ctl(), C_LU);
        chk("lu_state0", state_o, 0);
        tick(); #1;
        chk("lu_state1", state_o, 1);
        chk("lu_ignored", ctl(), C_NONE);
        idle(); tick();
        chk("lu_state2", state_o, 0);
        chk("lu_stall_cnt", stall_cnt, 1);

        // x0 destination and unused rs2 never stall
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1; #1;
        chk("x0_ctl", ctl(), C_NONE);
        tick();
        ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b0; #1;
        chk("unused_rs2_ctl", ctl(), C_NONE);
        id_uses_rs2 = 1'b1; #1;
        chk("used_rs2_ctl", ctl(), C_LU);
        id_uses_rs2 = 1'b0;
        tick();
        chk("nostall_state", state_o, 0);
        chk("nostall_cnt", stall_cnt, 1);
        idle();

        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        chk("clr_stall", stall_cnt, 0);

        // Redirect wins over a simultaneous load-use
        set_lu(); ex_redirect = 1'b1; #1;
        chk("redir_ctl", ctl(), C_FLUSH);
        tick();
        chk("redir_state", state_o, 0);
        chk("redir_flush_cnt", flush_cnt, 1);
        chk("redir_stall_cnt", stall_cnt, 0);
        idle();

        // Redirect arriving while in LU_STALL
        set_lu(); tick(); idle(); ex_redirect = 1'b1; #1;
        chk("lus_state", state_o, 1);
        chk("lus_redir_ctl", ctl(), C_FLUSH);
        tick(); idle();
        chk("lus_redir_state", state_o, 0);
        chk("lus_flush_cnt", flush_cnt, 2);
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;

        // Memory wait for three cycles with a redirect pending throughout
        mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_ctl", ctl(), C_FREEZE);
            chk("mw_state", state_o, (i == 0) ? 0 : 2);
            tick();
        end
        chk("mw_state_end", state_o, 2);
        chk("mw_stall_cnt", stall_cnt, 3);
        mem_ready = 1'b1; #1;
        chk("mw_release_ctl", ctl(), C_NONE);
        ex_redirect = 1'b0;
        tick();
        chk("mw_run", state_o, 0);
        chk("mw_stall_final", stall_cnt, 3);
        chk("mw_flush_final", flush_cnt, 0);
        idle();

        // Saturation of the narrow counters
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_lu(); tick(); idle(); tick();
        end
        chk("sat_stall4", stall_cnt, 15);
        chk("sat_stall16", stall16, 20);
        set_lu(); stat_clr = 1'b1; #1;
        chk("clr_evt_ctl", ctl(), C_LU);
        tick();
        chk("clr_evt_stall4", stall_cnt, 0);
        chk("clr_evt_stall16", stall16, 0);
        idle(); tick();

        // Reset pulse in the middle of a memory wait
        mem_req = 1'b1; mem_ready = 1'b0; tick(); #1;
        chk("pre_rst_state", state_o, 2);
        chk("pre_rst_stall", stall_cnt, 1);
        reset = 1'b0; #1;
        chk("mid_rst_ctl", ctl(), C_NONE);
        chk("mid_rst_state", state_o, 0);
        chk("mid_rst_stall", stall_cnt, 0);
        idle(); #1;
        reset = 1'b1;
        tick();
        chk("post_rst_state", state_o, 0);
        chk("post_rst_stall", stall_cnt, 0);
        chk("post_rst_flush", flush_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
